// File: rtl/mc_pkg.sv
// Shared sizing and FSM state type for the operand memory controller.
package mc_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DEPTH  = 64;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM,
        DONE
    } state_e;

endpackage

// File: rtl/mem_controller.sv
// Loads operand pairs into an external dual-output RAM, then streams them back
// to a consumer through a ready/valid interface with a registered output stage.
module mem_controller #(
    parameter int unsigned DATA_W = mc_pkg::DATA_W,
    parameter int unsigned ADDR_W = mc_pkg::ADDR_W,
    parameter int unsigned DEPTH  = mc_pkg::DEPTH
) (
    input  logic              mem_clk,
    input  logic              mem_rst,
    input  logic              flush,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_opa,
    input  logic [DATA_W-1:0] ld_opb,
    input  logic              ld_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mc_address_mem_opa,
    output logic [ADDR_W-1:0] mc_address_mem_opb,
    output logic [DATA_W-1:0] mem_data_in_opa,
    output logic [DATA_W-1:0] mem_data_in_opb,
    input  logic [DATA_W-1:0] mem_data_out_opa,
    input  logic [DATA_W-1:0] mem_data_out_opb,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              op_last,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count
);
    import mc_pkg::*;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              op_valid_q, op_valid_d;
    logic              op_last_q, op_last_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic [ADDR_W-1:0] addr;
    logic              accept;
    logic              consume;

    always_ff @(posedge mem_clk or posedge mem_rst) begin
        if (mem_rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            op_valid_q <= 1'b0;
            op_last_q  <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            op_valid_q <= op_valid_d;
            op_last_q  <= op_last_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        op_valid_d = op_valid_q;
        op_last_d  = op_last_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        ld_ready   = 1'b0;
        mem_we     = 1'b0;
        accept     = 1'b0;
        addr       = wr_ptr_q[ADDR_W-1:0];
        consume    = op_valid_q & op_ready;

        case (state_q)
            IDLE: begin
                ld_ready = (wr_ptr_q < DEPTH_C);
                accept   = ld_valid & ld_ready;
                if (accept) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = ONE_C;
                    count_d  = ONE_C;
                    state_d  = ld_last ? STREAM : LOAD;
                end
            end
            LOAD: begin
                ld_ready = (wr_ptr_q < DEPTH_C);
                accept   = ld_valid & ld_ready;
                if (accept) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + ONE_C;
                    count_d  = count_q + ONE_C;
                    if (ld_last || (wr_ptr_q == DEPTH_C - ONE_C)) begin
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                addr = rd_ptr_q[ADDR_W-1:0];
                // RAM read data is combinational, so the output register fills
                // whenever it is empty or being drained this cycle.
                if ((rd_ptr_q < count_q) && (!op_valid_q || op_ready)) begin
                    op_a_d     = mem_data_out_opa;
                    op_b_d     = mem_data_out_opb;
                    op_valid_d = 1'b1;
                    op_last_d  = (rd_ptr_q == count_q - ONE_C);
                    rd_ptr_d   = rd_ptr_q + ONE_C;
                end else if (consume) begin
                    op_valid_d = 1'b0;
                    op_last_d  = 1'b0;
                end
                if (consume && op_last_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d    = IDLE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            op_valid_d = 1'b0;
            op_last_d  = 1'b0;
            mem_we     = 1'b0;
        end
        if (mem_rst) begin
            mem_we = 1'b0;
        end
    end

    assign mc_address_mem_opa = addr;
    assign mc_address_mem_opb = addr;
    assign mem_data_in_opa    = ld_opa;
    assign mem_data_in_opb    = ld_opb;
    assign op_valid           = op_valid_q;
    assign op_last            = op_last_q;
    assign op_a               = op_a_q;
    assign op_b               = op_b_q;
    assign count              = count_q;
    assign busy               = (state_q != IDLE);
    assign done               = (state_q == DONE);

endmodule

// File: tb/tb_mem_controller.sv
// Self-checking bench: a load/stream reference model built from queues of the
// pairs written, with an external RAM model answering reads combinationally.
module tb_mem_controller;

    logic        mem_clk = 1'b0;
    logic        mem_rst;
    logic        flush;
    logic        ld_valid;
    logic        ld_ready;
    logic [63:0] ld_opa, ld_opb;
    logic        ld_last;
    logic        mem_we;
    logic [5:0]  addr_a, addr_b;
    logic [63:0] din_a, din_b, dout_a, dout_b;
    logic        op_valid, op_ready, op_last;
    logic [63:0] op_a, op_b;
    logic        busy, done;
    logic [6:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] ram_a [64];
    logic [63:0] ram_b [64];

    logic [63:0] ref_a [$];
    logic [63:0] ref_b [$];
    logic [63:0] got_a [$];
    logic [63:0] got_b [$];
    bit          got_last [$];

    int load_err, done_cnt, stall_err, first_valid_c, first_xfer_c, last_xfer_c;
    bit timed_out;

    always #5 mem_clk = ~mem_clk;

    always @(posedge mem_clk) begin
        if (mem_we) begin
            ram_a[addr_a] <= din_a;
            ram_b[addr_b] <= din_b;
        end
    end
    assign dout_a = ram_a[addr_a];
    assign dout_b = ram_b[addr_b];

    mem_controller #(.DATA_W(64), .ADDR_W(6), .DEPTH(64)) dut (
        .mem_clk(mem_clk), .mem_rst(mem_rst), .flush(flush),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_opa(ld_opa), .ld_opb(ld_opb),
        .ld_last(ld_last), .mem_we(mem_we),
        .mc_address_mem_opa(addr_a), .mc_address_mem_opb(addr_b),
        .mem_data_in_opa(din_a), .mem_data_in_opb(din_b),
        .mem_data_out_opa(dout_a), .mem_data_out_opb(dout_b),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .op_last(op_last), .busy(busy), .done(done), .count(count)
    );

    // Drives n beats back to back; the expected stream is simply the beats in order.
    task automatic load_beats(input int n, input bit use_last, input bit fixed);
        ref_a.delete();
        ref_b.delete();
        load_err = 0;
        for (int i = 0; i < n; i++) begin
            logic [63:0] a, b;
            if (fixed) begin
                a = 64'(17 * (i + 1));
                b = 64'(161 + i);
            end else begin
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
            end
            @(negedge mem_clk);
            ld_valid = 1'b1;
            ld_opa   = a;
            ld_opb   = b;
            ld_last  = use_last && (i == n - 1);
            #1;
            if (!(ld_ready === 1'b1 && mem_we === 1'b1 && addr_a === 6'(i) &&
                  addr_b === 6'(i) && din_a === a && din_b === b)) load_err++;
            ref_a.push_back(a);
            ref_b.push_back(b);
        end
        @(posedge mem_clk);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    // mode 0: ready always high, 1: ready pattern 1,0,0,1 repeating, 2: random ready.
    task automatic run_stream(input int mode, input int stop_after, input int budget);
        bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bit          prev_stall = 1'b0;
        logic [63:0] pa = '0, pb = '0;
        logic        pl = 1'b0;
        got_a.delete();
        got_b.delete();
        got_last.delete();
        done_cnt = 0; stall_err = 0;
        first_valid_c = -1; first_xfer_c = -1; last_xfer_c = -1;
        timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge mem_clk);
            case (mode)
                0:       op_ready = 1'b1;
                1:       op_ready = pat[c % 4];
                default: op_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (done === 1'b1) done_cnt++;
            if (prev_stall && (op_valid !== 1'b1 || op_a !== pa || op_b !== pb || op_last !== pl))
                stall_err++;
            if (op_valid === 1'b1 && first_valid_c < 0) first_valid_c = c;
            if (op_valid === 1'b1 && op_ready) begin
                got_a.push_back(op_a);
                got_b.push_back(op_b);
                got_last.push_back(op_last);
                if (first_xfer_c < 0) first_xfer_c = c;
                last_xfer_c = c;
            end
            prev_stall = (op_valid === 1'b1) && !op_ready;
            pa = op_a; pb = op_b; pl = op_last;
            if (stop_after >= 0 && got_a.size() == stop_after) begin
                timed_out = 1'b0;
                break;
            end
            if (done_cnt > 0 && done !== 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    function automatic int seq_errors();
        int e = 0;
        if (got_a.size() != ref_a.size()) return 1000;
        foreach (ref_a[i]) begin
            if (got_a[i] !== ref_a[i] || got_b[i] !== ref_b[i]) e++;
            if (got_last[i] != (i == ref_a.size() - 1)) e++;
        end
        return e;
    endfunction

    task automatic test_reset();
        mem_rst = 1'b1; flush = 1'b0; ld_valid = 1'b1; ld_last = 1'b0;
        ld_opa = '0; ld_opb = '0; op_ready = 1'b0;
        repeat (3) @(posedge mem_clk);
        #1;
        n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", mem_we); end
        n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_status: busy %b done %b want 0 0", busy, done); end
        n_tests++; if (count !== 7'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_tests++; if (op_valid !== 1'b0 || op_last !== 1'b0 || op_a !== 64'd0 || op_b !== 64'd0) begin
            n_fail++; $display("FAIL reset_op: valid %b last %b a %0h b %0h want all 0", op_valid, op_last, op_a, op_b); end
        ld_valid = 1'b0;
        @(negedge mem_clk);
        mem_rst = 1'b0;
        #1;
        n_tests++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ld_ready: got %b want 1", ld_ready); end
    endtask

    task automatic test_basic4();
        load_beats(4, 1'b1, 1'b1);
        run_stream(0, -1, 50);
        n_tests++; if (timed_out) begin n_fail++; $display("FAIL basic_timeout: got timeout want done"); end
        n_tests++; if (load_err != 0) begin n_fail++; $display("FAIL basic_load: got %0d bad beats want 0", load_err); end
        n_tests++; if (first_valid_c != 1) begin n_fail++; $display("FAIL basic_first_valid: got cycle %0d want 1", first_valid_c); end
        n_tests++; if (seq_errors() != 0) begin n_fail++; $display("FAIL basic_seq: got %0d errors want 0", seq_errors()); end
        n_tests++; if (last_xfer_c - first_xfer_c != 3) begin n_fail++; $display("FAIL basic_throughput: got span %0d want 3", last_xfer_c - first_xfer_c); end
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt); end
        n_tests++; if (count !== 7'd4 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_count: got count %0d busy %b want 4 0", count, busy); end
    endtask

    task automatic test_stall();
        load_beats(4, 1'b1, 1'b1);
        run_stream(1, -1, 80);
        n_tests++; if (timed_out) begin n_fail++; $display("FAIL stall_timeout: got timeout want done"); end
        n_tests++; if (stall_err != 0) begin n_fail++; $display("FAIL stall_stable: got %0d changes want 0", stall_err); end
        n_tests++; if (seq_errors() != 0) begin n_fail++; $display("FAIL stall_seq: got %0d errors want 0", seq_errors()); end
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL stall_done: got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_full64();
        load_beats(64, 1'b0, 1'b0);
        @(negedge mem_clk);
        ld_valid = 1'b1;
        #1;
        n_tests++; if (ld_ready !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL full_ld_ready: got ready %b we %b want 0 0", ld_ready, mem_we); end
        n_tests++; if (count !== 7'd64) begin n_fail++; $display("FAIL full_count: got %0d want 64", count); end
        ld_valid = 1'b0;
        run_stream(0, -1, 300);
        n_tests++; if (timed_out || load_err != 0) begin n_fail++; $display("FAIL full_run: got timeout %b load_err %0d want 0 0", timed_out, load_err); end
        n_tests++; if (seq_errors() != 0) begin n_fail++; $display("FAIL full_seq: got %0d errors want 0", seq_errors()); end
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL full_done: got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_single();
        load_beats(1, 1'b1, 1'b0);
        run_stream(0, -1, 30);
        n_tests++; if (timed_out || first_valid_c != 1) begin n_fail++; $display("FAIL single_timing: got timeout %b first %0d want 0 1", timed_out, first_valid_c); end
        n_tests++; if (seq_errors() != 0) begin n_fail++; $display("FAIL single_seq: got %0d errors want 0", seq_errors()); end
        n_tests++; if (done_cnt != 1 || count !== 7'd1) begin n_fail++; $display("FAIL single_done: got pulses %0d count %0d want 1 1", done_cnt, count); end
    endtask

    task automatic test_reset_mid();
        load_beats(5, 1'b1, 1'b0);
        run_stream(0, 2, 30);
        @(posedge mem_clk);
        #1;
        mem_rst  = 1'b1;
        ld_valid = 1'b1;
        #1;
        n_tests++; if (op_valid !== 1'b0 || op_last !== 1'b0 || op_a !== 64'd0 || op_b !== 64'd0) begin
            n_fail++; $display("FAIL rstmid_op: valid %b last %b a %0h b %0h want all 0", op_valid, op_last, op_a, op_b); end
        n_tests++; if (busy !== 1'b0 || done !== 1'b0 || count !== 7'd0 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_status: busy %b done %b count %0d we %b want 0 0 0 0", busy, done, count, mem_we); end
        ld_valid = 1'b0;
        @(negedge mem_clk);
        mem_rst = 1'b0;
        load_beats(3, 1'b1, 1'b0);
        run_stream(2, -1, 60);
        n_tests++; if (timed_out || load_err != 0) begin n_fail++; $display("FAIL rstmid_run: got timeout %b load_err %0d want 0 0", timed_out, load_err); end
        n_tests++; if (seq_errors() != 0 || done_cnt != 1) begin n_fail++; $display("FAIL rstmid_seq: got errors %0d pulses %0d want 0 1", seq_errors(), done_cnt); end
    endtask

    task automatic test_flush();
        int done_seen = 0;
        load_beats(3, 1'b0, 1'b0);
        @(negedge mem_clk);
        flush = 1'b1; ld_valid = 1'b1;
        #1;
        n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL flush_we: got %b want 0", mem_we); end
        @(posedge mem_clk);
        #1;
        flush = 1'b0; ld_valid = 1'b0;
        n_tests++; if (count !== 7'd0 || busy !== 1'b0 || op_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_state: count %0d busy %b valid %b want 0 0 0", count, busy, op_valid); end
        repeat (3) begin
            @(negedge mem_clk);
            if (done === 1'b1) done_seen++;
        end
        n_tests++; if (done_seen != 0) begin n_fail++; $display("FAIL flush_done: got %0d pulses want 0", done_seen); end
        load_beats(2, 1'b1, 1'b0);
        n_tests++; if (load_err != 0) begin n_fail++; $display("FAIL flush_reload_addr: got %0d bad beats want 0", load_err); end
        run_stream(2, -1, 60);
        n_tests++; if (timed_out || seq_errors() != 0 || done_cnt != 1) begin
            n_fail++; $display("FAIL flush_reload_seq: timeout %b errors %0d pulses %0d want 0 0 1", timed_out, seq_errors(), done_cnt); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            int n = int'($urandom_range(1, 40));
            load_beats(n, 1'b1, 1'b0);
            run_stream(2, -1, 400);
            n_tests++; if (timed_out || load_err != 0 || stall_err != 0) begin
                n_fail++; $display("FAIL random_run%0d: timeout %b load_err %0d stall %0d want 0 0 0", k, timed_out, load_err, stall_err); end
            n_tests++; if (seq_errors() != 0 || done_cnt != 1 || count !== 7'(n)) begin
                n_fail++; $display("FAIL random_seq%0d: errors %0d pulses %0d count %0d want 0 1 %0d", k, seq_errors(), done_cnt, count, n); end
        end
    endtask

    initial begin
        test_reset();
        test_basic4();
        test_stall();
        test_full64();
        test_single();
        test_reset_mid();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
